// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the LDPC intrinsic-LLR loader.
// The loader packs a byte stream into row-weight-wide decoder words.
package ldpc_pkg;

  localparam int LLR_WIDTH    = 8;
  localparam int ROW_WEIGHT   = 24;
  localparam int GF_SIZE      = 256;
  localparam int START_CYCLES = 2;
  localparam int WORD_W       = LLR_WIDTH * ROW_WEIGHT;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } ldpc_state_e;

endpackage

// File: rtl/ldpc_lane_packer.sv
// Collects ROW_WEIGHT consecutive LLR bytes and presents them as one word.
// word_valid pulses for one cycle when a newly completed word appears on word.
module ldpc_lane_packer
  import ldpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_en,
  input  logic [LLR_WIDTH-1:0] byte_data,
  input  logic                 clear,
  output logic [WORD_W-1:0]    word,
  output logic                 word_valid,
  output logic [4:0]           lane_cnt
);

  localparam int STAGE_W = WORD_W - LLR_WIDTH;

  // Bytes enter at the top and shift down, so after 23 bytes lane 0 sits at bit 0.
  logic [STAGE_W-1:0] stage;
  logic               lane_end;

  assign lane_end = (lane_cnt == 5'(ROW_WEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      lane_cnt   <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane_cnt <= '0;
      end else if (byte_en) begin
        if (lane_end) begin
          word       <= {byte_data, stage};
          word_valid <= 1'b1;
          lane_cnt   <= '0;
        end else begin
          stage    <= {byte_data, stage[STAGE_W-1:LLR_WIDTH]};
          lane_cnt <= lane_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ldpc_llr_loader.sv
// Byte-serial LLR feeder for ldpc_runner_top: writes GF_SIZE packed words per frame,
// pulses ini_st, then holds off the next frame until the decoder reports dec_done.
module ldpc_llr_loader
  import ldpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  // Stream handshake: a byte transfers on any rising edge where s_llr_valid and
  // s_llr_ready are both high; the source must hold data/last stable until then.
  input  logic                 s_llr_valid,
  output logic                 s_llr_ready,
  input  logic [LLR_WIDTH-1:0] s_llr_data,
  input  logic                 s_llr_last,
  output logic                 in_info_wren,
  output logic [WORD_W-1:0]    rece_llr_intri,
  output logic                 ini_st,
  input  logic                 dec_done,
  output logic                 busy,
  output logic                 frame_err,
  output ldpc_state_e          dbg_state
);

  ldpc_state_e state, state_nx;
  logic [8:0]  word_cnt;
  logic [4:0]  lane_cnt;
  logic [1:0]  st_cnt;
  logic        out_en;
  logic        frame_full;
  logic        accept;
  logic        lane_end;
  logic        final_byte;
  logic        early_last;

  assign accept     = s_llr_valid && s_llr_ready;
  assign lane_end   = (lane_cnt == 5'(ROW_WEIGHT - 1));
  assign final_byte = accept && lane_end && (word_cnt == 9'(GF_SIZE - 1));
  assign early_last = accept && s_llr_last && !final_byte;

  ldpc_lane_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_en    (accept),
    .byte_data  (s_llr_data),
    .clear      (early_last),
    .word       (rece_llr_intri),
    .word_valid (in_info_wren),
    .lane_cnt   (lane_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      word_cnt   <= '0;
      st_cnt     <= '0;
      out_en     <= 1'b0;
      frame_full <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      out_en     <= 1'b1;
      // frame_full marks the strobe cycle of the final word; it drives the move to START.
      frame_full <= final_byte;
      frame_err  <= accept && (s_llr_last != final_byte);
      if (early_last || final_byte) begin
        word_cnt <= '0;
      end else if (accept && lane_end) begin
        word_cnt <= word_cnt + 9'd1;
      end
      if (state == ST_START) begin
        st_cnt <= st_cnt + 2'd1;
      end else begin
        st_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD:  if (frame_full) state_nx = ST_START;
      ST_START: if (st_cnt == 2'(START_CYCLES - 1)) state_nx = ST_WAIT;
      ST_WAIT:  if (dec_done) state_nx = ST_LOAD;
      default:  state_nx = ST_LOAD;
    endcase
  end

  // Ready drops during the last strobe so no byte of the next frame slips in before START.
  assign s_llr_ready = out_en && (state == ST_LOAD) && !frame_full;
  assign ini_st      = (state == ST_START);
  assign busy        = (state != ST_LOAD) || (lane_cnt != 5'd0) || (word_cnt != 9'd0) || frame_full;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Directed bench for ldpc_llr_loader with a word scoreboard and output monitor.
module tb_ldpc_llr_loader;
  import ldpc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_llr_valid = 1'b0;
  logic                 s_llr_last = 1'b0;
  logic [LLR_WIDTH-1:0] s_llr_data = '0;
  logic                 dec_done = 1'b0;
  logic                 s_llr_ready;
  logic                 in_info_wren;
  logic [WORD_W-1:0]    rece_llr_intri;
  logic                 ini_st;
  logic                 busy;
  logic                 frame_err;
  ldpc_state_e          dbg_state;

  ldpc_llr_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_llr_valid    (s_llr_valid),
    .s_llr_ready    (s_llr_ready),
    .s_llr_data     (s_llr_data),
    .s_llr_last     (s_llr_last),
    .in_info_wren   (in_info_wren),
    .rece_llr_intri (rece_llr_intri),
    .ini_st         (ini_st),
    .dec_done       (dec_done),
    .busy           (busy),
    .frame_err      (frame_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] acc_word = '0;
  int wren_cnt = 0, ini_cnt = 0, err_cnt = 0;
  int last_wren_cyc = 0;
  bit have_prev = 0, chk_spacing = 0, prev_wren = 0, prev_ini = 0;
  int t_first = 0, t_last = 0;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_info_wren) begin
        wren_cnt++;
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL wren_unexpected: observed strobe with word %0h, expected no strobe", rece_llr_intri);
        end
        if (exp_q.size() != 0) check("word", rece_llr_intri, exp_q.pop_front());
        if (chk_spacing && have_prev) check("wren_spacing", cyc - last_wren_cyc, 48);
        have_prev     = 1;
        last_wren_cyc = cyc;
      end
      if (ini_st) begin
        ini_cnt++;
        if (!prev_ini) check("ini_after_wren", prev_wren, 1);
      end
      if (frame_err) err_cnt++;
    end
    prev_wren = in_info_wren;
    prev_ini  = ini_st;
  end

  // ---------------- driver tasks ----------------
  task automatic put_byte(input logic [7:0] d, input bit last, input bit gap);
    int t = 0;
    s_llr_valid = 1'b1;
    s_llr_data  = d;
    s_llr_last  = last;
    while (!s_llr_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_llr_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed ready=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk); #1;
    s_llr_valid = 1'b0;
    s_llr_last  = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // last_at < 0 omits last; an early last_at ends the frame on that byte.
  task automatic send_frame(input int nbytes, input int last_at, input bit gap, input bit rnd);
    logic [7:0] d;
    int lane;
    bit early;
    early = (last_at >= 0) && (last_at < GF_SIZE * ROW_WEIGHT - 1);
    for (int k = 0; k < nbytes; k++) begin
      d    = rnd ? 8'($urandom_range(0, 255)) : 8'(k % 256);
      lane = k % ROW_WEIGHT;
      acc_word[lane*LLR_WIDTH +: LLR_WIDTH] = d;
      if (lane == ROW_WEIGHT - 1 && !(early && k >= last_at)) exp_q.push_back(acc_word);
      put_byte(d, k == last_at, gap);
      if (k == 0) t_first = cyc;
      t_last = cyc;
    end
  endtask

  task automatic frame_checks(input int wren0, input int ini0, input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_wren_count"}, wren_cnt - wren0, GF_SIZE);
    check({tag, "_ini_cycles"}, ini_cnt - ini0, START_CYCLES);
    check({tag, "_state_wait"}, dbg_state, ST_WAIT);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_wait"}, s_llr_ready, 0);
  endtask

  task automatic pulse_done(input string tag);
    dec_done = 1'b1;
    @(posedge clk); #1;
    dec_done = 1'b0;
    check({tag, "_ready_after_done"}, s_llr_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  int w0, i0, e0;
  initial begin
    #2;
    check("rst_ready", s_llr_ready, 0);
    check("rst_wren", in_info_wren, 0);
    check("rst_word", rece_llr_intri, 0);
    check("rst_ini", ini_st, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err, 0);
    check("rst_state", dbg_state, ST_LOAD);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_held_low", s_llr_ready, 0);
    @(posedge clk); #1;
    check("ready_after_rst", s_llr_ready, 1);

    // dec_done while loading is ignored
    dec_done = 1'b1;
    @(posedge clk); #1;
    dec_done = 1'b0;
    check("done_ignored_state", dbg_state, ST_LOAD);
    check("done_ignored_err", frame_err, 0);

    // test 1: back-to-back frame
    w0 = wren_cnt; i0 = ini_cnt; e0 = err_cnt;
    send_frame(6144, 6143, 0, 0);
    check("t1_cycles", t_last - t_first, 6143);
    frame_checks(w0, i0, "t1");
    check("t1_no_err", err_cnt - e0, 0);

    // test 3: valid held while waiting on the decoder
    s_llr_valid = 1'b1;
    s_llr_data  = 8'hA5;
    w0 = wren_cnt;
    for (int c = 0; c < 100; c++) begin
      check("t3_wait_ready", s_llr_ready, 0);
      @(posedge clk); #1;
    end
    s_llr_valid = 1'b0;
    check("t3_no_wren", wren_cnt - w0, 0);
    check("t3_state", dbg_state, ST_WAIT);
    pulse_done("t3");

    // test 2: valid toggling, 48-cycle word spacing
    w0 = wren_cnt; i0 = ini_cnt;
    chk_spacing = 1; have_prev = 0;
    send_frame(6144, 6143, 1, 0);
    frame_checks(w0, i0, "t2");
    chk_spacing = 0;
    pulse_done("t2");

    // test 4: early last on byte 1000
    w0 = wren_cnt; i0 = ini_cnt; e0 = err_cnt;
    send_frame(1001, 1000, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_err_pulses", err_cnt - e0, 1);
    check("t4_wren_count", wren_cnt - w0, 41);
    check("t4_no_ini", ini_cnt - i0, 0);
    check("t4_state", dbg_state, ST_LOAD);
    check("t4_busy", busy, 0);
    check("t4_ready", s_llr_ready, 1);
    w0 = wren_cnt; i0 = ini_cnt;
    send_frame(6144, 6143, 0, 0);
    frame_checks(w0, i0, "t4b");
    pulse_done("t4b");

    // test 5: missing last, random data
    w0 = wren_cnt; i0 = ini_cnt; e0 = err_cnt;
    send_frame(6144, -1, 0, 1);
    frame_checks(w0, i0, "t5");
    check("t5_err_pulses", err_cnt - e0, 1);
    pulse_done("t5");

    // test 6a: reset in the middle of word 100
    send_frame(100 * ROW_WEIGHT + 10, -1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6a_wren", in_info_wren, 0);
    check("t6a_word", rece_llr_intri, 0);
    check("t6a_ready", s_llr_ready, 0);
    check("t6a_busy", busy, 0);
    check("t6a_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6a_ready_release", s_llr_ready, 1);

    // test 6b: reset on the first ini_st cycle
    send_frame(6144, 6143, 0, 0);
    @(posedge clk); #1;
    check("t6b_ini_high", ini_st, 1);
    rst_n = 1'b0;
    #1;
    check("t6b_ini_drop", ini_st, 0);
    check("t6b_state", dbg_state, ST_LOAD);
    check("t6b_word", rece_llr_intri, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fresh frame after reset: word 0 must be bytes 0..23
    w0 = wren_cnt; i0 = ini_cnt;
    send_frame(6144, 6143, 0, 0);
    frame_checks(w0, i0, "t6c");
    pulse_done("t6c");
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
